// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial framing bundle for piso_serializer
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output load_valid, load_data,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with one-word holding buffer
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus
);
  localparam int CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  assign accept   = bus.load_valid && !hold_full_q;
  assign last_bit = (cnt_q == CNT_LAST);
  assign shifted  = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          // Held word wins over a direct load; load_ready is low then anyway.
          cnt_d = '0;
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = bus.load_data;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          hold_d      = bus.load_data;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign bus.load_ready = !hold_full_q;
  assign bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout_last  = (state_q == SHIFT) && last_bit;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer, MSB-first and LSB-first instances
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         lv;
  logic [W-1:0] ld;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) if_m ();
  piso_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.load_valid = lv;
  assign if_m.load_data  = ld;
  assign if_l.load_valid = lv;
  assign if_l.load_data  = ld;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l.slave));

  int checks = 0;
  int errors = 0;

  // Each entry is {expected sout, expected sout_last}, in emission order.
  logic [1:0] qm[$];
  logic [1:0] ql[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge rst) begin
    qm.delete();
    ql.delete();
  end

  // Accepted words become expected bit streams.
  always @(posedge clk) begin
    if (!rst && lv && if_m.load_ready) begin
      for (int i = W - 1; i >= 0; i--) qm.push_back({ld[i], i == 0});
      for (int i = 0; i < W; i++)      ql.push_back({ld[i], i == W - 1});
    end
  end

  // A pending bit must appear every cycle; more than one frame pending means the hold is full.
  task automatic mon(input string tag, input logic v, input logic s, input logic l,
                     input logic b, input logic r, input int sz, input logic [1:0] hd);
    chk({tag, "_valid"}, v, sz != 0);
    chk({tag, "_busy"}, b, sz != 0);
    chk({tag, "_ready"}, r, sz <= W);
    if (sz != 0 && v) begin
      chk({tag, "_sout"}, s, hd[1]);
      chk({tag, "_last"}, l, hd[0]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon("msb", if_m.sout_valid, if_m.sout, if_m.sout_last, if_m.busy, if_m.load_ready,
          qm.size(), (qm.size() != 0) ? qm[0] : 2'b00);
      mon("lsb", if_l.sout_valid, if_l.sout, if_l.sout_last, if_l.busy, if_l.load_ready,
          ql.size(), (ql.size() != 0) ? ql[0] : 2'b00);
      if (qm.size() != 0) void'(qm.pop_front());
      if (ql.size() != 0) void'(ql.pop_front());
    end
  end

  task automatic rst_check(input string tag);
    chk({tag, "_m_sout"}, if_m.sout, 1'b0);
    chk({tag, "_m_valid"}, if_m.sout_valid, 1'b0);
    chk({tag, "_m_last"}, if_m.sout_last, 1'b0);
    chk({tag, "_m_busy"}, if_m.busy, 1'b0);
    chk({tag, "_m_ready"}, if_m.load_ready, 1'b1);
    chk({tag, "_l_valid"}, if_l.sout_valid, 1'b0);
    chk({tag, "_l_busy"}, if_l.busy, 1'b0);
    chk({tag, "_l_ready"}, if_l.load_ready, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] w);
    bit acc = 1'b0;
    lv = 1'b1;
    ld = w;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (if_m.load_ready && !rst) begin
        acc = 1'b1;
        break;
      end
    end
    #1 lv = 1'b0;
    ld = $urandom;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qm.size() == 0 && ql.size() == 0 && !if_m.busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    #2 rst_check("rst_init");
    @(posedge clk);
    #1 rst = 1'b0;

    send(8'hA5);
    wait_idle();

    send(8'hA5);
    send(8'h3C);
    wait_idle();

    send(8'hF0);
    repeat (7) @(posedge clk);
    #1 send(8'h0F);
    wait_idle();

    send(8'h01);
    wait_idle();

    // Abort mid-frame with a word held.
    send(8'hA5);
    send(8'h3C);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 rst_check("rst_mid");
    #1 rst = 1'b0;
    send(8'hFF);
    wait_idle();

    #3 rst = 1'b1;
    #1 rst_check("rst_idle");
    #1 rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      lv = ($urandom_range(0, 3) != 0) && ((c % 200) < 170);
      ld = $urandom;
    end
    lv = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
